ahb_addr_decoder: RTL and testbench

Parametrised AHB-lite address decoder and slave-response multiplexer for the interconnect between the single bus master and up to 8 slaves. It decodes the address-phase Haddr into a one-hot Hsel. It registers the data-phase owner and multiplexes that owner's Hrdata, Hreadyout and Hresp back to the master. Unmapped accesses are routed to a built-in default slave, which returns the two-cycle AHB ERROR response and counts errors.

---
 rtl/ahb_addr_decoder.sv | 125 ++++++++++++
 tb/tb_ahb_addr_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_addr_decoder.sv
// AHB-lite address decoder and slave-response multiplexer with a built-in
// default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_addr_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_LSB    = 28,
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 8
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    input  logic [ADDR_W-1:0]            Haddr,
    input  logic [1:0]                   Htrans,
    output logic [NUM_SLAVES-1:0]        Hsel,
    input  logic [NUM_SLAVES*DATA_W-1:0] Hrdata_s,
    input  logic [NUM_SLAVES-1:0]        Hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        Hresp_s,
    output logic [DATA_W-1:0]            Hrdata,
    output logic                         Hready,
    output logic                         Hresp,
    output logic [CNT_W-1:0]             Herr_cnt
);

    localparam int DEF = NUM_SLAVES;
    localparam logic [NUM_SLAVES:0] DSEL_DEF = {1'b1, {NUM_SLAVES{1'b0}}};

    typedef enum logic [1:0] {
        D_IDLE,
        D_ERR1,
        D_ERR2
    } dflt_state_t;

    logic [SEL_W-1:0]    idx;
    logic                mapped;
    logic                err_start;
    logic [NUM_SLAVES:0] dsel;
    dflt_state_t         d_state;
    logic                d_ready;
    logic                d_resp;
    logic                unused_bits;

    assign idx       = Haddr[SEL_LSB +: SEL_W];
    assign mapped    = {1'b0, idx} < (SEL_W+1)'(NUM_SLAVES);
    assign err_start = Hready && !mapped && Htrans[1];

    // Address bits outside the region field and Htrans[0] play no part in decode.
    assign unused_bits = ^{Haddr, Htrans[0]};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        Hsel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            Hsel[i] = (idx == SEL_W'(i));
        end
    end

    // The data-phase owner drives the response; the default slave is the fallback.
    always_comb begin
        Hrdata = '0;
        Hready = ~dsel[DEF] | d_ready;
        Hresp  = dsel[DEF] & d_resp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                Hrdata = Hrdata_s[i*DATA_W +: DATA_W];
                Hready = Hreadyout_s[i];
                Hresp  = Hresp_s[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            dsel <= DSEL_DEF;
        end else if (Hready) begin
            dsel <= mapped ? {1'b0, Hsel} : DSEL_DEF;
        end
    end

    // Default slave: ready/resp are registered alongside the state they belong to.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            d_state  <= D_IDLE;
            d_ready  <= 1'b1;
            d_resp   <= 1'b0;
            Herr_cnt <= '0;
        end else begin
            case (d_state)
                D_IDLE: begin
                    if (err_start) begin
                        d_state <= D_ERR1;
                        d_ready <= 1'b0;
                        d_resp  <= 1'b1;
                    end
                end
                D_ERR1: begin
                    d_state <= D_ERR2;
                    d_ready <= 1'b1;
                    d_resp  <= 1'b1;
                end
                D_ERR2: begin
                    if (Herr_cnt != '1) begin
                        Herr_cnt <= Herr_cnt + CNT_W'(1);
                    end
                    if (err_start) begin
                        d_state <= D_ERR1;
                        d_ready <= 1'b0;
                        d_resp  <= 1'b1;
                    end else begin
                        d_state <= D_IDLE;
                        d_ready <= 1'b1;
                        d_resp  <= 1'b0;
                    end
                end
                default: begin
                    d_state <= D_IDLE;
                    d_ready <= 1'b1;
                    d_resp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Scoreboard bench for ahb_addr_decoder: stimulus queues expected data-phase
// responses, a monitor pops and compares each one as the transfer completes.
module tb_ahb_addr_decoder;

    localparam int NS = 4;
    localparam int DW = 32;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic        resp;
        logic        resp_wait;
        logic [7:0]  cnt;
    } exp_t;

    logic           Hclk;
    logic           Hreset;
    logic [31:0]    Haddr;
    logic [1:0]     Htrans;
    logic [NS-1:0]  Hsel;
    logic [NS*DW-1:0] Hrdata_s;
    logic [NS-1:0]  Hreadyout_s;
    logic [NS-1:0]  Hresp_s;
    logic [DW-1:0]  Hrdata;
    logic           Hready;
    logic           Hresp;
    logic [7:0]     Herr_cnt;

    logic [NS-1:0]  hsel2;
    logic [DW-1:0]  hrdata2;
    logic           hready2;
    logic           hresp2;
    logic [1:0]     herr_cnt2;

    logic [31:0]    sdata [NS];
    exp_t           exp_q [$];
    int             checks = 0;
    int             errors = 0;

    ahb_addr_decoder dut (
        .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Htrans(Htrans), .Hsel(Hsel),
        .Hrdata_s(Hrdata_s), .Hreadyout_s(Hreadyout_s), .Hresp_s(Hresp_s),
        .Hrdata(Hrdata), .Hready(Hready), .Hresp(Hresp), .Herr_cnt(Herr_cnt)
    );

    ahb_addr_decoder #(.CNT_W(2)) dut_sat (
        .Hclk(Hclk), .Hreset(Hreset), .Haddr(Haddr), .Htrans(Htrans), .Hsel(hsel2),
        .Hrdata_s(Hrdata_s), .Hreadyout_s(Hreadyout_s), .Hresp_s(Hresp_s),
        .Hrdata(hrdata2), .Hready(hready2), .Hresp(hresp2), .Herr_cnt(herr_cnt2)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    always_comb begin
        Hrdata_s = '0;
        for (int i = 0; i < NS; i++) begin
            Hrdata_s[i*DW +: DW] = sdata[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int w, input logic [31:0] d, input logic r,
                                input logic rw, input logic [7:0] c);
        exp_t e;
        e.waits = w; e.rdata = d; e.resp = r; e.resp_wait = rw; e.cnt = c;
        return e;
    endfunction

    task automatic addr_phase(input logic [31:0] a, input logic [1:0] t,
                              input logic push, input exp_t e);
        Haddr  = a;
        Htrans = t;
        if (push) exp_q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            @(negedge Hclk);
            if (Hready) break;
        end
        check("accept_ready", 32'(Hready), 32'd1);
        @(posedge Hclk); #1;
    endtask

    task automatic idle(input int n);
        Htrans = 2'b00;
        repeat (n) begin
            @(posedge Hclk); #1;
        end
    endtask

    // Monitor: tracks accepted NONSEQ/SEQ transfers and checks their data phase.
    initial begin
        logic active;
        int   waits;
        exp_t e;
        active = 1'b0;
        waits  = 0;
        forever begin
            @(negedge Hclk);
            if (Hreset) begin
                active = 1'b0;
                waits  = 0;
            end else begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_transfer", 32'(exp_q.size()), 32'd1);
                        active = 1'b0;
                    end else if (!Hready) begin
                        waits++;
                        check("resp_during_wait", 32'(Hresp), 32'(exp_q[0].resp_wait));
                    end else begin
                        e = exp_q.pop_front();
                        check("wait_states", 32'(waits), 32'(e.waits));
                        check("rdata", Hrdata, e.rdata);
                        check("resp", 32'(Hresp), 32'(e.resp));
                        check("err_cnt_at_done", 32'(Herr_cnt), 32'(e.cnt));
                        waits = 0;
                    end
                end
                if (Hready) active = Htrans[1];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t none;
        none = mk(0, 32'h0, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < NS; i++) sdata[i] = 32'h1111_1111 * (i + 1);
        Hreset      = 1'b1;
        Haddr       = 32'h0;
        Htrans      = 2'b00;
        Hreadyout_s = '1;
        Hresp_s     = '0;

        // Reset state
        repeat (2) @(posedge Hclk);
        #1 Hreset = 1'b0;
        @(negedge Hclk);
        check("rst_hready", 32'(Hready), 32'd1);
        check("rst_hresp", 32'(Hresp), 32'd0);
        check("rst_hrdata", Hrdata, 32'h0);
        check("rst_cnt", 32'(Herr_cnt), 32'd0);
        check("rst_hsel", 32'(Hsel), 32'b0001);
        check("rst_sat_hsel", 32'(hsel2), 32'b0001);
        check("rst_sat_hrdata", hrdata2, 32'h0);
        check("rst_sat_hresp", 32'(hresp2), 32'd0);

        // Decode sweep, including both ends of the region field
        begin
            logic [31:0] addrs [6];
            logic [3:0]  sels  [6];
            addrs = '{32'h0FFF_FFFF, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                      32'h4000_0000, 32'hF000_0000};
            sels  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
            for (int i = 0; i < 6; i++) begin
                Haddr = addrs[i];
                #1 check("decode_hsel", 32'(Hsel), 32'(sels[i]));
            end
        end
        @(posedge Hclk); #1;

        // Zero-wait read from slave 3
        addr_phase(32'h3000_0000, 2'b10, 1'b1, mk(0, 32'h4444_4444, 1'b0, 1'b0, 8'd0));
        idle(1);

        // Slave 2 inserts two wait states while the master moves on to slave 1
        addr_phase(32'h2000_0010, 2'b10, 1'b1, mk(2, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd0));
        Hreadyout_s[2] = 1'b0;
        sdata[2]       = 32'hDEAD_BEEF;
        Haddr          = 32'h1000_0000;
        #1 check("wait_addr_hsel", 32'(Hsel), 32'b0010);
        @(posedge Hclk); #1;
        @(posedge Hclk); #1;
        Hreadyout_s[2] = 1'b1;
        addr_phase(32'h1000_0000, 2'b10, 1'b1, mk(0, 32'h2222_2222, 1'b0, 1'b0, 8'd0));
        idle(1);
        sdata[2] = 32'h3333_3333;

        // Single unmapped NONSEQ
        addr_phase(32'h5000_0000, 2'b10, 1'b1, mk(1, 32'h0, 1'b1, 1'b1, 8'd0));
        idle(2);
        check("cnt_after_one", 32'(Herr_cnt), 32'd1);
        check("sat_cnt_after_one", 32'(herr_cnt2), 32'd1);

        // Three back-to-back unmapped SEQ transfers
        for (int i = 0; i < 3; i++) begin
            addr_phase(32'h5000_0004 + 32'(4 * i), 2'b11, 1'b1,
                       mk(1, 32'h0, 1'b1, 1'b1, 8'(1 + i)));
        end
        idle(2);
        check("cnt_after_four", 32'(Herr_cnt), 32'd4);
        check("sat_cnt_after_four", 32'(herr_cnt2), 32'd3);

        // Unmapped IDLE: zero-wait OKAY, no count
        Haddr  = 32'h5000_0000;
        Htrans = 2'b00;
        #1 check("idle_unmapped_hsel", 32'(Hsel), 32'b0000);
        @(posedge Hclk); #1;
        @(negedge Hclk);
        check("idle_unmapped_hready", 32'(Hready), 32'd1);
        check("idle_unmapped_hresp", 32'(Hresp), 32'd0);
        idle(2);
        check("idle_unmapped_cnt", 32'(Herr_cnt), 32'd4);

        // Mapped slave ERROR passes through and is not counted
        addr_phase(32'h0000_0040, 2'b10, 1'b1, mk(1, 32'h1111_1111, 1'b1, 1'b1, 8'd4));
        Hreadyout_s[0] = 1'b0;
        Hresp_s[0]     = 1'b1;
        Htrans         = 2'b00;
        @(posedge Hclk); #1;
        Hreadyout_s[0] = 1'b1;
        @(posedge Hclk); #1;
        Hresp_s[0] = 1'b0;
        idle(2);
        check("slave_err_cnt", 32'(Herr_cnt), 32'd4);

        // Saturation: five more unmapped NONSEQ transfers
        for (int i = 0; i < 5; i++) begin
            addr_phase(32'h7000_0000, 2'b10, 1'b1, mk(1, 32'h0, 1'b1, 1'b1, 8'(4 + i)));
        end
        idle(2);
        check("cnt_after_nine", 32'(Herr_cnt), 32'd9);
        check("sat_cnt_held", 32'(herr_cnt2), 32'd3);

        // Reset while the default slave is in D_ERR1
        addr_phase(32'h6000_0000, 2'b10, 1'b0, none);
        Hreset = 1'b1;
        Htrans = 2'b00;
        @(negedge Hclk);
        check("err1_hready", 32'(Hready), 32'd0);
        check("err1_hresp", 32'(Hresp), 32'd1);
        Hreadyout_s = '0;
        @(posedge Hclk); #1;
        @(negedge Hclk);
        check("rst_err1_hready", 32'(Hready), 32'd1);
        check("rst_err1_hresp", 32'(Hresp), 32'd0);
        check("rst_err1_hrdata", Hrdata, 32'h0);
        check("rst_err1_cnt", 32'(Herr_cnt), 32'd0);
        check("rst_err1_sat_cnt", 32'(herr_cnt2), 32'd0);
        check("rst_err1_sat_hready", 32'(hready2), 32'd1);
        @(posedge Hclk); #1;
        Hreset      = 1'b0;
        Hreadyout_s = '1;
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
